// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - weight preload and diagonally skewed activation feeder for the systolic PE array
module pe_array_feeder #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               w_valid,
  input  logic [COLS*DW-1:0] w_data,
  output logic               w_ready,
  input  logic               a_valid,
  input  logic [ROWS*DW-1:0] a_data,
  input  logic               a_last,
  output logic               a_ready,
  output logic [COLS*DW-1:0] pe_win,
  output logic               pe_wwrite,
  output logic [ROWS*DW-1:0] pe_datain,
  output logic [ROWS-1:0]    pe_active,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(ROWS) + 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;
  localparam logic [CW-1:0] LAST_CNT = CW'(ROWS - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [COLS*DW-1:0] win_q, win_d;
  logic               wwrite_q, wwrite_d;
  logic               w_hs, a_hs;

  assign w_ready = (state_q == LOAD_W);
  assign a_ready = (state_q == STREAM);
  assign w_hs    = w_valid & w_ready;
  assign a_hs    = a_valid & a_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    win_d    = w_hs ? w_data : win_q;
    wwrite_d = w_hs;
    case (state_q)
      // A start overlapping the done pulse only counts if it is still held a cycle later.
      IDLE: if (start && !done_q) begin
        state_d = LOAD_W;
        cnt_d   = '0;
      end
      LOAD_W: if (w_hs) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: if (a_hs && a_last) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      win_q    <= '0;
      wwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      win_q    <= win_d;
      wwrite_q <= wwrite_d;
    end
  end

  // Row r is a free-running r+1 stage delay line; non-handshake cycles inject zero/inactive bubbles.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] d_q [0:r];
    logic [r:0]    v_q;

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        for (int s = 0; s <= r; s++) d_q[s] <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= a_hs ? a_data[r*DW +: DW] : '0;
        v_q[0] <= a_hs;
        for (int s = 1; s <= r; s++) begin
          d_q[s] <= d_q[s-1];
          v_q[s] <= v_q[s-1];
        end
      end
    end

    assign pe_datain[r*DW +: DW] = d_q[r];
    assign pe_active[r]          = v_q[r];
  end

  assign pe_win    = win_q;
  assign pe_wwrite = wwrite_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_pe_array_feeder.sv
// tb/tb_pe_array_feeder.sv - self-checking bench for pe_array_feeder with a job-level schedule model
module tb_pe_array_feeder;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic w_valid = 1'b0;
  logic a_valid = 1'b0;
  logic a_last = 1'b0;
  logic [COLS*DW-1:0] w_data = '0;
  logic [ROWS*DW-1:0] a_data = '0;
  logic w_ready, a_ready, pe_wwrite, busy, done;
  logic [COLS*DW-1:0] pe_win;
  logic [ROWS*DW-1:0] pe_datain;
  logic [ROWS-1:0]    pe_active;

  int n_checks = 0;
  int n_errors = 0;

  pe_array_feeder #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .pe_win(pe_win), .pe_wwrite(pe_wwrite), .pe_datain(pe_datain),
    .pe_active(pe_active), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: accepted vectors are scheduled into future cycle slots, one per row offset.
  int phase;
  int wcnt;
  int e;
  int drain_end;
  logic m_done, m_wwrite;
  logic [COLS*DW-1:0] m_win;
  logic [ROWS*DW-1:0] m_datain;
  logic [ROWS-1:0]    m_active;
  logic [DW-1:0] sd_data [16][ROWS];
  logic          sd_act  [16][ROWS];

  task automatic m_reset();
    phase = 0; wcnt = 0; e = 0; drain_end = 0;
    m_done = 1'b0; m_wwrite = 1'b0; m_win = '0; m_datain = '0; m_active = '0;
    for (int s = 0; s < 16; s++)
      for (int r = 0; r < ROWS; r++) begin
        sd_data[s][r] = '0;
        sd_act[s][r]  = 1'b0;
      end
  endtask

  initial begin
    logic prev_done;
    int slot;
    m_reset();
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) m_reset();
      else begin
        prev_done = m_done;
        m_done = 1'b0;
        m_wwrite = 1'b0;
        e++;
        case (phase)
          0: if (start && !prev_done) begin phase = 1; wcnt = 0; end
          1: if (w_valid) begin
            m_win = w_data; m_wwrite = 1'b1; wcnt++;
            if (wcnt == ROWS) phase = 2;
          end
          2: if (a_valid) begin
            for (int r = 0; r < ROWS; r++) begin
              sd_data[(e + r) % 16][r] = a_data[r*DW +: DW];
              sd_act[(e + r) % 16][r]  = 1'b1;
            end
            if (a_last) begin phase = 3; drain_end = e + ROWS; end
          end
          default: if (e == drain_end) begin m_done = 1'b1; phase = 0; end
        endcase
        slot = e % 16;
        for (int r = 0; r < ROWS; r++) begin
          m_datain[r*DW +: DW] = sd_data[slot][r];
          m_active[r] = sd_act[slot][r];
          sd_data[slot][r] = '0;
          sd_act[slot][r]  = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    chk("cmp_win", pe_win, m_win);
    chk("cmp_wwrite", pe_wwrite, m_wwrite);
    chk("cmp_datain", pe_datain, m_datain);
    chk("cmp_active", pe_active, m_active);
    chk("cmp_done", done, m_done);
    chk("cmp_busy", busy, phase != 0);
    chk("cmp_w_ready", w_ready, phase == 1);
    chk("cmp_a_ready", a_ready, phase == 2);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic load_weights(input logic [31:0] base);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    w_valid = 1'b1;
    for (int i = 0; i < ROWS; i++) begin
      w_data = base + 32'(i);
      @(negedge clock);
    end
    w_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] wexp;
    logic [5:0] pat;
    logic [31:0] bub_data [3];
    logic [31:0] bub_exp [7];
    logic [3:0]  bub_act [7];
    bub_data = '{32'h44332211, 32'hdeadbeef, 32'h88776655};
    bub_exp  = '{32'h00000011, 32'h00002200, 32'h00330055, 32'h44006600,
                 32'h00770000, 32'h88000000, 32'h00000000};
    bub_act  = '{4'b0001, 4'b0010, 4'b0101, 4'b1010, 4'b0100, 4'b1000, 4'b0000};

    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_datain", pe_datain, 0);
    chk("rst_w_ready", w_ready, 0);
    resetn = 1'b1;

    // weight load with continuous w_valid
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("t1_busy", busy, 1);
    w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_data = {4{8'(4 * (i + 1))}};
      @(negedge clock);
      chk("t1_win", pe_win, {4{8'(4 * (i + 1))}});
      chk("t1_wwrite", pe_wwrite, 1);
    end
    w_valid = 1'b0;
    chk("t1_a_ready", a_ready, 1);
    chk("t1_w_ready", w_ready, 0);

    // skew stream, with a start pulse during DRAIN
    a_valid = 1'b1; a_data = 32'h04030201;
    @(negedge clock);
    chk("t3_wwrite_off", pe_wwrite, 0);
    chk("t3_d0", pe_datain, 32'h00000001); chk("t3_a0", pe_active, 4'b0001);
    a_data = 32'h08070605; a_last = 1'b1;
    @(negedge clock);
    chk("t3_d1", pe_datain, 32'h00000205); chk("t3_a1", pe_active, 4'b0011);
    a_valid = 1'b0; a_last = 1'b0; a_data = 32'hdeadbeef;
    @(negedge clock);
    chk("t3_d2", pe_datain, 32'h00030600); chk("t3_a2", pe_active, 4'b0110);
    chk("t3_a_ready", a_ready, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("t3_d3", pe_datain, 32'h04070000); chk("t3_a3", pe_active, 4'b1100);
    @(negedge clock);
    chk("t3_d4", pe_datain, 32'h08000000); chk("t3_a4", pe_active, 4'b1000);
    chk("t3_no_done", done, 0);
    @(negedge clock);
    chk("t3_done", done, 1); chk("t3_busy", busy, 0); chk("t3_a5", pe_active, 0);
    @(negedge clock);
    chk("t6_done_once", done, 0); chk("t6_idle", busy, 0);

    // weight backpressure: w_valid 1,0,1,1,0,1
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    pat = 6'b101101;
    wexp = '0;
    for (int i = 0; i < 6; i++) begin
      w_valid = pat[i];
      w_data = 32'h11111111 * 32'(i + 1);
      @(negedge clock);
      if (pat[i]) wexp = 32'h11111111 * 32'(i + 1);
      chk("t2_wwrite", pe_wwrite, pat[i]);
      chk("t2_win", pe_win, wexp);
      chk("t2_a_ready", a_ready, i == 5);
    end
    w_valid = 1'b0;

    // bubble: a_valid 1,0,1
    for (int i = 0; i < 7; i++) begin
      a_valid = (i == 0) || (i == 2);
      a_last  = (i == 2);
      a_data  = (i < 3) ? bub_data[i] : 32'h0;
      @(negedge clock);
      chk("t4_datain", pe_datain, bub_exp[i]);
      chk("t4_active", pe_active, bub_act[i]);
      chk("t4_done", done, i == 6);
    end
    a_valid = 1'b0; a_last = 1'b0;

    // reset two cycles into STREAM
    load_weights(32'ha0a0a0a0);
    a_valid = 1'b1; a_data = 32'h0d0c0b0a;
    @(negedge clock);
    a_data = 32'h1d1c1b1a;
    @(negedge clock);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("t5_busy", busy, 0); chk("t5_done", done, 0);
    chk("t5_active", pe_active, 0); chk("t5_datain", pe_datain, 0);
    chk("t5_win", pe_win, 0); chk("t5_a_ready", a_ready, 0);
    @(negedge clock);
    a_valid = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // fresh job with a_last on the first vector; start held only in the done cycle
    load_weights(32'h5a5a5a00);
    chk("t5b_win", pe_win, 32'h5a5a5a03);
    a_valid = 1'b1; a_last = 1'b1; a_data = 32'h01020304;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      a_valid = 1'b0; a_last = 1'b0;
      chk("t5b_done", done, i == 4);
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("t5b_start_on_done", busy, 0);
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
Upstream feeder for the systolic PE array. Runs the preload/stream sequence for the array:
- Loads one column of stationary weights through the PE weight chain (win/wwrite).
- Streams activation vectors into the array rows with the diagonal skew the array needs: row r is delayed r cycles.
- Drives per-row active flags, then drains the skew and signals completion.

Parameters:
ROWS, 4, number of PE rows fed (skew depth ROWS-1), must be >= 2
COLS, 4, number of PE columns receiving weights in parallel
DW, 8, data/weight element width in bits

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a load/stream job; sampled only in IDLE
w_valid  in  1  weight word valid
w_data  in  COLS*DW  one weight per column, column c at bits [c*DW +: DW]
w_ready  out  1  weight word accepted when w_valid & w_ready
a_valid  in  1  activation vector valid
a_data  in  ROWS*DW  one activation per row, row r at bits [r*DW +: DW]
a_last  in  1  marks final activation vector of job
a_ready  out  1  activation accepted when a_valid & a_ready
pe_win  out  COLS*DW  weight bus to top PE of each column
pe_wwrite  out  1  weight shift strobe to PE array
pe_datain  out  ROWS*DW  skewed activation to left PE of each row
pe_active  out  ROWS  per-row active flag, aligned with pe_datain
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Clock and reset: one clock, reset is asynchronous and active-low. Port names are clock and resetn.
- Reset values: all outputs 0, state IDLE, skew registers and counters 0. Reset asserted mid-job aborts immediately with no done pulse.
- All outputs are registered; none is combinational from an input, except w_ready and a_ready, which decode the current state.
- State IDLE:
  - w_ready=0, a_ready=0.
  - start=1 -> LOAD_W, weight counter cleared.
- State LOAD_W:
  - w_ready=1, a_ready=0, pe_active all 0.
  - Handshake at edge k: pe_win=w_data and pe_wwrite=1 for the cycle after edge k; weight counter +1.
  - Cycle without handshake: pe_wwrite=0 next cycle, pe_win holds its value.
  - After the ROWS-th accepted word -> STREAM.
- State STREAM:
  - a_ready=1, w_ready=0, pe_wwrite=0.
  - The skew pipeline shifts every cycle whether or not a handshake occurs.
  - Handshake at edge k: row r presents a_data[r] with pe_active[r]=1 after edge k+r, for one cycle.
  - Cycle without handshake: row 0 injects data 0 with active=0 (bubble); the bubble propagates down the skew identically.
  - Handshake with a_last=1 -> DRAIN. a_last without a_valid is ignored.
- State DRAIN:
  - a_ready=0; the skew keeps shifting with zero/inactive injection.
  - Last vector accepted at edge k -> done=1 and busy=0 for the cycle after edge k+ROWS, then IDLE.
  - After edge k+ROWS all pe_active bits are 0.
- start outside IDLE is ignored. start and done in the same cycle: start is honoured in the following IDLE cycle only if it is still held.
- Widths: no arithmetic on data; elements pass through bit-exact. Counters are clog2(ROWS)+1 bits and never wrap within a job.
- A job with a_last on its first vector is legal.
- Throughput: one weight per cycle in LOAD_W, one activation vector per cycle in STREAM.

Test Plan:
- Weight load, ROWS=COLS=4.
  - Stimulus: start; w_valid continuous, w_data = 0x04040404, 0x08080808, 0x0C0C0C0C, 0x10101010.
  - Required: pe_wwrite high exactly 4 consecutive cycles, pe_win in that order, then a_ready=1.
- Weight backpressure.
  - Stimulus: w_valid pattern 1,0,1,1,0,1.
  - Required: pe_wwrite follows the accepted cycles only; pe_win holds through gaps; STREAM is entered after the 4th accept.
- Skew stream.
  - Stimulus: vectors a_data = 0x04030201 at edge k, then 0x08070605 with a_last at edge k+1.
  - Required: row0 = 01,05 after edges k,k+1; row3 = 04,08 after edges k+3,k+4; pe_active is a matching diagonal; done pulses after edge k+5.
- Bubble.
  - Stimulus: a_valid 1,0,1.
  - Required: each row shows data, 0/inactive, data in a 3-cycle window offset by r.
- Reset mid-STREAM.
  - Stimulus: drop resetn two cycles after the first activation.
  - Required: all outputs 0 asynchronously, no done pulse; a new job afterwards runs correctly.
- start while busy.
  - Stimulus: pulse start during DRAIN.
  - Required: ignored; a single done pulse, then IDLE.
